// File: rtl/udp_send_buffer_pkg.sv
// ---------------------------------------------------------------------------
// udp_send_buffer_pkg
// Shared definitions for the UDP transmit-side packet buffer:
//   - rd_state_t  : read-side FSM state encoding (IDLE/START/SEND/DRAIN)
//   - DEF_MAX_LEN : default maximum payload bytes per packet
// ---------------------------------------------------------------------------
package udp_send_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SEND  = 2'd2,
    ST_DRAIN = 2'd3
  } rd_state_t;

  localparam int DEF_MAX_LEN = 1472;

endpackage

// File: rtl/udp_send_buffer_sync_fifo.sv
// ---------------------------------------------------------------------------
// udp_sync_fifo
// Single-clock FIFO with a registered output (one-cycle read latency).
// dout holds its value until the next successful read.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   wr_en, din     : write request and data (ignored when full)
//   rd_en          : read request (ignored when empty)
//   dout           : registered read data
//   full, empty    : status flags derived from the registered fill count
//   count          : number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module udp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Storage array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_rd) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/udp_send_buffer.sv
// ---------------------------------------------------------------------------
// udp_send_buffer
// Transmit-side packet buffer between an AXI-Stream byte source and the UDP
// transmit engine. Payload bytes go into a data FIFO, each packet's byte
// count into a length FIFO. A packet is only handed to the engine once it is
// completely written, so the data FIFO never underflows on the read side.
// Ports:
//   udp_tx_clk_i, resetn       : clock, asynchronous active-low reset
//   send_s_data_t*             : AXI-Stream byte sink (tdata/tvalid/tlast/tready)
//   udp_tx_start_o             : one-cycle start pulse to the engine
//   udp_tx_num_o               : byte count of the packet being sent
//   udp_tx_req_i/udp_tx_data_o : per-byte request, data one cycle later
//   udp_tx_done_i              : engine finished (or aborted) the packet
//   cached_pkt_num             : complete packets stored and not yet started
// ---------------------------------------------------------------------------
module udp_send_buffer
  import udp_send_buffer_pkg::*;
#(
  parameter int DATA_DEPTH = 2048,
  parameter int PKT_DEPTH  = 16,
  parameter int MAX_LEN    = DEF_MAX_LEN
) (
  input  logic                       udp_tx_clk_i,
  input  logic                       resetn,
  input  logic [7:0]                 send_s_data_tdata,
  input  logic                       send_s_data_tvalid,
  input  logic                       send_s_data_tlast,
  output logic                       send_s_data_tready,
  output logic                       udp_tx_start_o,
  output logic [15:0]                udp_tx_num_o,
  input  logic                       udp_tx_req_i,
  output logic [7:0]                 udp_tx_data_o,
  input  logic                       udp_tx_done_i,
  output logic [$clog2(PKT_DEPTH):0] cached_pkt_num
);

  localparam logic [15:0] LAST_IDX = 16'(MAX_LEN - 1);

  rd_state_t state;
  rd_state_t state_next;

  logic        ready_en;
  logic [15:0] wr_cnt;
  logic [15:0] rd_rem;
  logic [15:0] rem_next;
  logic        accept;
  logic        pkt_close;
  logic        data_full;
  logic        data_empty;
  logic        data_pop;
  logic        len_full;
  logic        len_empty;
  logic        len_pop;
  logic [15:0] len_dout;
  logic [$clog2(DATA_DEPTH):0] data_fill_unused;

  // Write side: the ready flag only depends on registered state, so there
  // is no combinational path from tvalid to tready. ready_en keeps tready
  // low while in reset.
  assign send_s_data_tready = ready_en && !data_full && !len_full;
  assign accept    = send_s_data_tvalid && send_s_data_tready;
  // A packet closes on tlast or when it reaches MAX_LEN bytes (forced split).
  assign pkt_close = accept && (send_s_data_tlast || (wr_cnt == LAST_IDX));

  always_ff @(posedge udp_tx_clk_i or negedge resetn) begin
    if (!resetn) begin
      ready_en <= 1'b0;
      wr_cnt   <= '0;
    end else begin
      ready_en <= 1'b1;
      if (pkt_close) begin
        wr_cnt <= '0;
      end else if (accept) begin
        wr_cnt <= wr_cnt + 16'd1;
      end
    end
  end

  udp_sync_fifo #(
    .WIDTH (8),
    .DEPTH (DATA_DEPTH)
  ) u_data_fifo (
    .clk   (udp_tx_clk_i),
    .rst_n (resetn),
    .wr_en (accept),
    .din   (send_s_data_tdata),
    .rd_en (data_pop),
    .dout  (udp_tx_data_o),
    .full  (data_full),
    .empty (data_empty),
    .count (data_fill_unused)
  );

  // Length FIFO occupancy is exactly the number of complete packets that
  // have not yet been started, so its fill count drives cached_pkt_num.
  udp_sync_fifo #(
    .WIDTH (16),
    .DEPTH (PKT_DEPTH)
  ) u_len_fifo (
    .clk   (udp_tx_clk_i),
    .rst_n (resetn),
    .wr_en (pkt_close),
    .din   (wr_cnt + 16'd1),
    .rd_en (len_pop),
    .dout  (len_dout),
    .full  (len_full),
    .empty (len_empty),
    .count (cached_pkt_num)
  );

  // The length popped in IDLE appears on the registered FIFO output in
  // START and is held there until the next pop, which only happens after
  // the engine is done, so it serves directly as udp_tx_num_o.
  assign udp_tx_num_o   = len_dout;
  assign udp_tx_start_o = (state == ST_START);

  always_ff @(posedge udp_tx_clk_i or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      rd_rem <= '0;
    end else begin
      state  <= state_next;
      rd_rem <= rem_next;
    end
  end

  always_comb begin
    state_next = state;
    rem_next   = rd_rem;
    len_pop    = 1'b0;
    data_pop   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!len_empty) begin
          len_pop    = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        rem_next   = len_dout;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        // A request in the same cycle as done is served first; done then
        // looks at the remaining count after that pop.
        if (udp_tx_req_i && (rd_rem != 16'd0) && !data_empty) begin
          data_pop = 1'b1;
          rem_next = rd_rem - 16'd1;
        end
        if (udp_tx_done_i) begin
          state_next = (rem_next == 16'd0) ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Discard the bytes an aborting engine never asked for so the next
        // packet starts on its own first byte.
        if ((rd_rem != 16'd0) && !data_empty) begin
          data_pop = 1'b1;
          rem_next = rd_rem - 16'd1;
        end
        if (rem_next == 16'd0) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_udp_send_buffer.sv
// ---------------------------------------------------------------------------
// tb_udp_send_buffer
// Directed sequence with random payload bytes. The reference model is a flat
// byte stream plus a list of expected packet lengths; lengths are derived by
// splitting each written stream into MAX_LEN-sized chunks.
// ---------------------------------------------------------------------------
module tb_udp_send_buffer;

  localparam int DATA_DEPTH = 2048;
  localparam int PKT_DEPTH  = 16;
  localparam int MAX_LEN    = 1472;
  localparam int WAIT_LIMIT = 5000;

  logic        clk;
  logic        resetn;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;
  logic        start;
  logic [15:0] num;
  logic        req;
  logic [7:0]  data;
  logic        done;
  logic [4:0]  cached;

  udp_send_buffer #(
    .DATA_DEPTH (DATA_DEPTH),
    .PKT_DEPTH  (PKT_DEPTH),
    .MAX_LEN    (MAX_LEN)
  ) dut (
    .udp_tx_clk_i       (clk),
    .resetn             (resetn),
    .send_s_data_tdata  (tdata),
    .send_s_data_tvalid (tvalid),
    .send_s_data_tlast  (tlast),
    .send_s_data_tready (tready),
    .udp_tx_start_o     (start),
    .udp_tx_num_o       (num),
    .udp_tx_req_i       (req),
    .udp_tx_data_o      (data),
    .udp_tx_done_i      (done),
    .cached_pkt_num     (cached)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_bytes[$];
  int         exp_lens[$];
  int         starts[$];
  logic [7:0] last_byte;

  // Record the length presented with every start pulse.
  always @(negedge clk) begin
    if (resetn && start) starts.push_back(int'(num));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] b, input logic last);
    bit   ok;
    logic r;
    ok     = 1'b0;
    tdata  = b;
    tlast  = last;
    tvalid = 1'b1;
    for (int i = 0; i < WAIT_LIMIT; i++) begin
      r = tready;
      step();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'(ok), 32'd1);
  endtask

  // Writes one tlast-delimited stream of len bytes; base < 0 means random.
  task automatic send_pkt(input int len, input int base);
    logic [7:0] b;
    int rem;
    for (int i = 0; i < len; i++) begin
      b = (base < 0) ? 8'($urandom) : 8'(base + i);
      exp_bytes.push_back(b);
      send_beat(b, (i == len - 1));
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    rem = len;
    while (rem > 0) begin
      exp_lens.push_back((rem > MAX_LEN) ? MAX_LEN : rem);
      rem -= (rem > MAX_LEN) ? MAX_LEN : rem;
    end
  endtask

  task automatic wait_start(output int el);
    int cnt;
    cnt = 0;
    el  = 0;
    while (starts.size() == 0 && cnt < WAIT_LIMIT) begin
      step();
      cnt++;
    end
    if (starts.size() == 0) begin
      check("start_timeout", 32'(starts.size()), 32'd1);
    end else begin
      el = exp_lens.pop_front();
      check("start_num", 32'(starts.pop_front()), 32'(el));
    end
  endtask

  task automatic read_bytes(input int k);
    logic [7:0] e;
    for (int i = 0; i < k; i++) begin
      req = 1'b1;
      step();
      e = exp_bytes.pop_front();
      check("rd_data", 32'(data), 32'(e));
      last_byte = e;
    end
    req = 1'b0;
  endtask

  task automatic finish_pkt(input int el, input int got);
    if (got == el) begin
      req = 1'b1;
      step();
      req = 1'b0;
      check("req_at_zero_holds", 32'(data), 32'(last_byte));
    end
    done = 1'b1;
    step();
    done = 1'b0;
    for (int i = got; i < el; i++) void'(exp_bytes.pop_front());
  endtask

  task automatic serve(input int nread);
    int el;
    int k;
    wait_start(el);
    if (el > 0) begin
      k = (nread < 0 || nread > el) ? el : nread;
      read_bytes(k);
      finish_pkt(el, k);
    end
  endtask

  initial begin
    int el;
    resetn = 1'b0;
    tdata  = '0;
    tvalid = 1'b0;
    tlast  = 1'b0;
    req    = 1'b0;
    done   = 1'b0;
    last_byte = '0;

    // Reset state
    #1;
    check("rst_tready", 32'(tready), 32'd0);
    check("rst_start",  32'(start),  32'd0);
    check("rst_num",    32'(num),    32'd0);
    check("rst_data",   32'(data),   32'd0);
    check("rst_cached", 32'(cached), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    step();
    check("post_rst_tready", 32'(tready), 32'd1);

    // Single 4-byte packet A0..A3 with start timing
    send_pkt(4, 'hA0);
    check("t1_start_early", 32'(start), 32'd0);
    step();
    check("t1_start_pulse", 32'(start), 32'd1);
    check("t1_num", 32'(num), 32'd4);
    serve(-1);
    step();
    check("t1_cached_idle", 32'(cached), 32'd0);
    check("t1_no_restart", 32'(start), 32'd0);

    // Engine stalled on one packet while three more are queued
    send_pkt(3, -1);
    send_pkt(1, -1);
    send_pkt(5, -1);
    send_pkt(1472, -1);
    step();
    check("t2_cached3", 32'(cached), 32'd3);
    repeat (4) serve(-1);

    // 1500-byte stream is split into 1472 + 28
    send_pkt(1500, -1);
    serve(-1);
    serve(-1);

    // Abort after 2 of 10 bytes; following packet must stay aligned
    send_pkt(10, -1);
    send_pkt(6, -1);
    serve(2);
    serve(-1);

    // Fill the data FIFO completely
    for (int p = 0; p < 16; p++) send_pkt(128, -1);
    check("fill_tready_low", 32'(tready), 32'd0);
    check("fill_cached", 32'(cached), 32'd15);
    wait_start(el);
    read_bytes(100);
    check("fill_tready_back", 32'(tready), 32'd1);
    read_bytes(28);
    finish_pkt(el, 128);
    repeat (15) serve(-1);

    // Reset while sending with two packets stored
    send_pkt(4, -1);
    send_pkt(5, -1);
    send_pkt(6, -1);
    wait_start(el);
    read_bytes(1);
    check("t6_cached2", 32'(cached), 32'd2);
    resetn = 1'b0;
    #1;
    check("t6_rst_tready", 32'(tready), 32'd0);
    check("t6_rst_start",  32'(start),  32'd0);
    check("t6_rst_num",    32'(num),    32'd0);
    check("t6_rst_data",   32'(data),   32'd0);
    check("t6_rst_cached", 32'(cached), 32'd0);
    exp_bytes.delete();
    exp_lens.delete();
    starts.delete();
    step();
    step();
    resetn = 1'b1;
    step();
    check("t6_tready_back", 32'(tready), 32'd1);
    send_pkt(7, -1);
    serve(-1);
    step();
    check("t6_cached_end", 32'(cached), 32'd0);

    // Random packet lengths
    for (int p = 0; p < 6; p++) send_pkt(int'($urandom_range(1, 40)), -1);
    repeat (6) serve(-1);
    step();
    check("rand_cached_end", 32'(cached), 32'd0);
    check("rand_model_empty", 32'(exp_bytes.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
